azadi_jtag_dtm: RTL

Parametrised JTAG debug transport module that turns the pin-level JTAG port of `azadi_soc_top` into a DMI request/response handshake for `rv_dm`. It replaces the fixed-IDCODE TAP path and the separate DirectDmiTap build mode with one synthesizable, single-clock block. TCK is oversampled in the system clock domain, so the same RTL serves FPGA, silicon and Verilator (driven by `jtagdpi`) builds. It implements the standard 16-state TAP, an IR of configurable length, and the IDCODE, DTMCS, DMIACCESS and BYPASS data registers, with busy and error tracking.

---
 rtl/azadi_jtag_dtm.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/azadi_jtag_dtm.sv
// JTAG debug transport module: oversampled TAP controller feeding a DMI request/response engine.
// TCK/TMS/TDI/TRST are synchronised into the system clock domain; all TAP activity runs on detected TCK edges.
module azadi_jtag_dtm #(
    parameter int unsigned IrLength   = 5,
    parameter logic [31:0] IdCode     = 32'h04F5484D,
    parameter int unsigned AbitsW     = 7,
    parameter int unsigned SyncStages = 2
) (
    input  logic              clock,
    input  logic              reset_ni,
    input  logic              jtag_tck_i,
    input  logic              jtag_tms_i,
    input  logic              jtag_tdi_i,
    input  logic              jtag_trst_ni,
    output logic              jtag_tdo_o,
    output logic              jtag_tdo_oe_o,
    output logic              dmi_req_valid_o,
    input  logic              dmi_req_ready_i,
    output logic [AbitsW-1:0] dmi_req_addr_o,
    output logic [1:0]        dmi_req_op_o,
    output logic [31:0]       dmi_req_data_o,
    input  logic              dmi_rsp_valid_i,
    output logic              dmi_rsp_ready_o,
    input  logic [31:0]       dmi_rsp_data_i,
    input  logic [1:0]        dmi_rsp_resp_i,
    output logic              dmi_rst_no
);

    localparam int unsigned       DmiW       = AbitsW + 34;
    localparam logic [IrLength-1:0] IrIdcode = IrLength'(5'h01);
    localparam logic [IrLength-1:0] IrDtmcs  = IrLength'(5'h10);
    localparam logic [IrLength-1:0] IrDmi    = IrLength'(5'h11);
    localparam logic [5:0]        AbitsField = 6'(AbitsW);

    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
    } tap_e;

    typedef enum logic [1:0] {E_IDLE, E_REQ, E_RSP} eng_e;

    // First error wins: a non-zero sticky status is never overwritten.
    function automatic logic [1:0] sticky(input logic [1:0] cur, input logic [1:0] err);
        return (cur == 2'd0) ? err : cur;
    endfunction

    logic [SyncStages-1:0] tck_sync, tms_sync, tdi_sync, trst_sync;
    logic                  tck_prev;
    logic                  tck_s, tms_s, tdi_s, trst_s;
    logic                  tck_rise, tck_fall, tap_step;

    tap_e                  tap_q, tap_next;
    eng_e                  eng_q, eng_next;

    logic [IrLength-1:0]   ir, ir_sr;
    logic [31:0]           dr32;
    logic [DmiW-1:0]       dmi_sr;
    logic                  byp;
    logic                  tdo_mux, shifting;
    logic                  sel_idcode, sel_dtmcs, sel_dmi;
    logic [31:0]           dtmcs_val;

    logic [1:0]            dmistat;
    logic [AbitsW-1:0]     last_addr;
    logic [31:0]           last_rsp_data;
    logic                  upd_dr_p1;
    logic                  busy, cap_dmi, dmi_upd, launch, hard_rst, clr_stat, rsp_take;
    logic [1:0]            op_in;

    always_ff @(posedge clock or negedge reset_ni) begin
        if (!reset_ni) begin
            tck_sync  <= '0;
            tms_sync  <= '1;
            tdi_sync  <= '0;
            trst_sync <= '0;
            tck_prev  <= 1'b0;
        end else begin
            tck_sync  <= {tck_sync[SyncStages-2:0], jtag_tck_i};
            tms_sync  <= {tms_sync[SyncStages-2:0], jtag_tms_i};
            tdi_sync  <= {tdi_sync[SyncStages-2:0], jtag_tdi_i};
            trst_sync <= {trst_sync[SyncStages-2:0], jtag_trst_ni};
            tck_prev  <= tck_sync[SyncStages-1];
        end
    end

    assign tck_s    = tck_sync[SyncStages-1];
    assign tms_s    = tms_sync[SyncStages-1];
    assign tdi_s    = tdi_sync[SyncStages-1];
    assign trst_s   = trst_sync[SyncStages-1];
    assign tck_rise = tck_s & ~tck_prev;
    assign tck_fall = ~tck_s & tck_prev;
    assign tap_step = tck_rise & trst_s;

    always_ff @(posedge clock or negedge reset_ni) begin
        if (!reset_ni)      tap_q <= TLR;
        else if (!trst_s)   tap_q <= TLR;
        else if (tck_rise)  tap_q <= tap_next;
    end

    always_comb begin
        tap_next = tap_q;
        unique case (tap_q)
            TLR:    tap_next = tms_s ? TLR    : RTI;
            RTI:    tap_next = tms_s ? SEL_DR : RTI;
            SEL_DR: tap_next = tms_s ? SEL_IR : CAP_DR;
            CAP_DR: tap_next = tms_s ? EX1_DR : SH_DR;
            SH_DR:  tap_next = tms_s ? EX1_DR : SH_DR;
            EX1_DR: tap_next = tms_s ? UPD_DR : PAU_DR;
            PAU_DR: tap_next = tms_s ? EX2_DR : PAU_DR;
            EX2_DR: tap_next = tms_s ? UPD_DR : SH_DR;
            UPD_DR: tap_next = tms_s ? SEL_DR : RTI;
            SEL_IR: tap_next = tms_s ? TLR    : CAP_IR;
            CAP_IR: tap_next = tms_s ? EX1_IR : SH_IR;
            SH_IR:  tap_next = tms_s ? EX1_IR : SH_IR;
            EX1_IR: tap_next = tms_s ? UPD_IR : PAU_IR;
            PAU_IR: tap_next = tms_s ? EX2_IR : PAU_IR;
            EX2_IR: tap_next = tms_s ? UPD_IR : SH_IR;
            UPD_IR: tap_next = tms_s ? SEL_DR : RTI;
            default: tap_next = TLR;
        endcase
    end

    always_ff @(posedge clock or negedge reset_ni) begin
        if (!reset_ni) begin
            ir    <= IrIdcode;
            ir_sr <= '0;
        end else if (!trst_s || tap_q == TLR) begin
            ir    <= IrIdcode;
        end else if (tck_rise) begin
            if (tap_q == CAP_IR)     ir_sr <= IrLength'(2'b01);
            else if (tap_q == SH_IR) ir_sr <= {tdi_s, ir_sr[IrLength-1:1]};
            if (tap_next == UPD_IR)  ir    <= ir_sr;
        end
    end

    assign sel_idcode = (ir == IrIdcode);
    assign sel_dtmcs  = (ir == IrDtmcs);
    assign sel_dmi    = (ir == IrDmi);
    assign dtmcs_val  = {14'b0, 1'b0, 1'b0, 1'b0, 3'd1, dmistat, AbitsField, 4'd1};
    assign busy       = (eng_q != E_IDLE);

    // Data registers carry no reset; every scan starts with a capture.
    always_ff @(posedge clock) begin
        if (tap_step && tap_q == CAP_DR) begin
            dr32   <= sel_dtmcs ? dtmcs_val : IdCode;
            dmi_sr <= {last_addr, last_rsp_data, busy ? 2'd3 : dmistat};
            byp    <= 1'b0;
        end else if (tap_step && tap_q == SH_DR) begin
            dr32   <= {tdi_s, dr32[31:1]};
            dmi_sr <= {tdi_s, dmi_sr[DmiW-1:1]};
            byp    <= tdi_s;
        end
    end

    assign shifting = (tap_q == SH_DR) || (tap_q == SH_IR);

    always_comb begin
        tdo_mux = byp;
        if (tap_q == SH_IR)               tdo_mux = ir_sr[0];
        else if (sel_dmi)                 tdo_mux = dmi_sr[0];
        else if (sel_idcode || sel_dtmcs) tdo_mux = dr32[0];
    end

    always_ff @(posedge clock or negedge reset_ni) begin
        if (!reset_ni) begin
            jtag_tdo_o    <= 1'b0;
            jtag_tdo_oe_o <= 1'b0;
        end else if (tck_fall) begin
            jtag_tdo_o    <= shifting & tdo_mux;
            jtag_tdo_oe_o <= shifting;
        end
    end

    // Update-DR stage: acts one clock after the TCK rise that enters Update-DR.
    always_ff @(posedge clock or negedge reset_ni) begin
        if (!reset_ni) upd_dr_p1 <= 1'b0;
        else           upd_dr_p1 <= tap_step && (tap_next == UPD_DR);
    end

    assign op_in    = dmi_sr[1:0];
    assign cap_dmi  = tap_step && (tap_q == CAP_DR) && sel_dmi;
    assign dmi_upd  = upd_dr_p1 && sel_dmi;
    assign launch   = dmi_upd && !busy && (dmistat == 2'd0) && (op_in == 2'd1 || op_in == 2'd2);
    assign hard_rst = upd_dr_p1 && sel_dtmcs && dr32[17];
    assign clr_stat = upd_dr_p1 && sel_dtmcs && (dr32[16] || dr32[17]);
    assign rsp_take = (eng_q == E_RSP) && dmi_rsp_valid_i && !hard_rst;

    always_ff @(posedge clock or negedge reset_ni) begin
        if (!reset_ni) eng_q <= E_IDLE;
        else           eng_q <= eng_next;
    end

    always_comb begin
        eng_next = eng_q;
        if (hard_rst) begin
            eng_next = E_IDLE;
        end else begin
            unique case (eng_q)
                E_IDLE:  if (launch)          eng_next = E_REQ;
                E_REQ:   if (dmi_req_ready_i) eng_next = E_RSP;
                E_RSP:   if (dmi_rsp_valid_i) eng_next = E_IDLE;
                default: eng_next = E_IDLE;
            endcase
        end
    end

    assign dmi_req_valid_o = (eng_q == E_REQ);
    assign dmi_rsp_ready_o = (eng_q == E_RSP);

    always_ff @(posedge clock or negedge reset_ni) begin
        if (!reset_ni) begin
            dmistat        <= 2'd0;
            last_addr      <= '0;
            last_rsp_data  <= '0;
            dmi_req_addr_o <= '0;
            dmi_req_data_o <= '0;
            dmi_req_op_o   <= 2'd0;
            dmi_rst_no     <= 1'b1;
        end else begin
            dmi_rst_no <= !hard_rst;
            if (clr_stat) begin
                dmistat <= 2'd0;
            end else if ((cap_dmi || dmi_upd) && busy) begin
                dmistat <= sticky(dmistat, 2'd3);
            end else if (rsp_take && dmi_rsp_resp_i[1]) begin
                dmistat <= sticky(dmistat, dmi_rsp_resp_i);
            end
            if (launch) begin
                dmi_req_addr_o <= dmi_sr[DmiW-1:34];
                dmi_req_data_o <= dmi_sr[33:2];
                dmi_req_op_o   <= op_in;
                last_addr      <= dmi_sr[DmiW-1:34];
            end
            if (rsp_take) last_rsp_data <= dmi_rsp_data_i;
        end
    end

endmodule
